control_sequencer: RTL

- Moore-style control FSM for the 32-bit datapath.
- Steps fetch/decode/execute using the 5-bit opcode from the IR.
- Drives the register-select strobes (Gra/Grb/Grc, Rin, Rout, BAout) consumed by the select/encode stage, plus all bus-driver, register-enable, ALU-op and memory strobes.
- Waits on a memory ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 85 ++++++++
 rtl/control_word_decode.sv | 117 +++++++++++
 rtl/control_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, state encoding and control-word bit map for the control sequencer.
// No logic: constants, types and the opcode classifier only.
// Not applicable: no flow control lives here.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU code used for effective-address and branch-target additions
    localparam logic [4:0] ADD_OP_DEFAULT = 5'b00011;

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ALU_R, C_ALU_I, C_LDI, C_LD, C_ST, C_BR, C_JR, C_HALT
    } op_class_t;

    // Bit positions inside the flat control word
    localparam int CW_GRA     = 0;
    localparam int CW_GRB     = 1;
    localparam int CW_GRC     = 2;
    localparam int CW_RIN     = 3;
    localparam int CW_ROUT    = 4;
    localparam int CW_BAOUT   = 5;
    localparam int CW_PCOUT   = 6;
    localparam int CW_PCIN    = 7;
    localparam int CW_INCPC   = 8;
    localparam int CW_MARIN   = 9;
    localparam int CW_MDRIN   = 10;
    localparam int CW_MDROUT  = 11;
    localparam int CW_IRIN    = 12;
    localparam int CW_YIN     = 13;
    localparam int CW_ZIN     = 14;
    localparam int CW_ZLOWOUT = 15;
    localparam int CW_COUT    = 16;
    localparam int CW_CONIN   = 17;
    localparam int CW_READ    = 18;
    localparam int CW_WRITE   = 19;
    localparam int CW_W       = 20;

    // Any opcode not listed here executes as a nop
    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        c = C_NOP;
        if (op >= OP_ADD && op <= OP_OR) begin
            c = C_ALU_R;
        end else if (op >= OP_ADDI && op <= OP_ORI) begin
            c = C_ALU_I;
        end else begin
            case (op)
                OP_LDI:  c = C_LDI;
                OP_LD:   c = C_LD;
                OP_ST:   c = C_ST;
                OP_BR:   c = C_BR;
                OP_JR:   c = C_JR;
                OP_HALT: c = C_HALT;
                default: c = C_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/control_word_decode.sv
// Maps (state, opcode, con_ff) to the flat strobe vector and the ALU operation.
// Purely combinational, zero cycles.
// No flow control; waiting is decided by the sequencer.
module control_word_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] ADD_OP = ADD_OP_DEFAULT
) (
    input  logic [3:0]      state,
    input  logic [4:0]      opcode,
    input  logic            con_ff,
    output logic [CW_W-1:0] cw,
    output logic [4:0]      alu_op
);

    state_t    st;
    op_class_t cls;

    assign st  = state_t'(state);
    assign cls = op_class(opcode);

    // Per-step strobe table; everything not named in a step stays low
    always_comb begin
        cw     = '0;
        alu_op = '0;
        case (st)
            S_T0: begin
                cw[CW_PCOUT] = 1'b1; cw[CW_MARIN] = 1'b1;
                cw[CW_INCPC] = 1'b1; cw[CW_ZIN]   = 1'b1;
            end
            S_T1: begin
                cw[CW_ZLOWOUT] = 1'b1; cw[CW_PCIN]  = 1'b1;
                cw[CW_READ]    = 1'b1; cw[CW_MDRIN] = 1'b1;
            end
            S_T2: begin
                cw[CW_MDROUT] = 1'b1; cw[CW_IRIN] = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU_R, C_ALU_I: begin
                        cw[CW_GRB] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_YIN] = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        cw[CW_GRB] = 1'b1; cw[CW_BAOUT] = 1'b1; cw[CW_YIN] = 1'b1;
                    end
                    C_BR: begin
                        cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_CONIN] = 1'b1;
                    end
                    C_JR: begin
                        cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_PCIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU_R: begin
                        cw[CW_GRC] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                        alu_op = opcode;
                    end
                    C_ALU_I: begin
                        cw[CW_COUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                        alu_op = opcode;
                    end
                    C_LDI, C_LD, C_ST: begin
                        cw[CW_COUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                        alu_op = ADD_OP;
                    end
                    C_BR: begin
                        cw[CW_PCOUT] = 1'b1; cw[CW_YIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU_R, C_ALU_I, C_LDI: begin
                        cw[CW_ZLOWOUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1;
                    end
                    C_LD, C_ST: begin
                        cw[CW_ZLOWOUT] = 1'b1; cw[CW_MARIN] = 1'b1;
                    end
                    C_BR: begin
                        cw[CW_COUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                        alu_op = ADD_OP;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        cw[CW_READ] = 1'b1; cw[CW_MDRIN] = 1'b1;
                    end
                    C_ST: begin
                        cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_MDRIN] = 1'b1;
                    end
                    C_BR: begin
                        cw[CW_ZLOWOUT] = con_ff; cw[CW_PCIN] = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        cw[CW_MDROUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1;
                    end
                    C_ST: cw[CW_WRITE] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute step sequencer driving all datapath strobes from the state register.
// One step per clock; strobes follow the state combinationally (zero added latency).
// Stalls in memory steps until mem_ready (or the optional timeout); halts on stop/halt.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] ADD_OP      = ADD_OP_DEFAULT,
    parameter int         MEM_TIMEOUT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    input  logic       mem_ready,
    input  logic       stop,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       Cout,
    output logic       CONin,
    output logic       Read,
    output logic       Write,
    output logic [4:0] alu_op,
    output logic       run
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

    state_t          state;
    logic [15:0]     wait_cnt;
    op_class_t       cls;
    logic            waiting;
    logic            proceed;
    logic            last_step;
    logic [CW_W-1:0] cw_raw;
    logic [CW_W-1:0] cw;
    logic [4:0]      alu_raw;

    assign cls = op_class(opcode);

    // Memory steps that must see mem_ready (or the timeout) before moving on
    always_comb begin
        waiting = (state == S_T1)
               || (state == S_T6 && cls == C_LD)
               || (state == S_T7 && cls == C_ST);
        proceed = mem_ready || ((MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT));
    end

    // Final step of each instruction class; stop is honoured only here
    always_comb begin
        last_step = ((state == S_T3) && (cls == C_JR || cls == C_NOP))
                 || ((state == S_T5) && (cls == C_ALU_R || cls == C_ALU_I || cls == C_LDI))
                 || ((state == S_T6) && (cls == C_BR))
                 || ((state == S_T7) && (cls == C_LD || cls == C_ST));
    end

    // Step sequencer with memory-wait stall and timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_T0;
            wait_cnt <= '0;
        end else if (waiting && !proceed) begin
            if (MEM_TIMEOUT != 0) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end else begin
            wait_cnt <= '0;
            if (state == S_T3 && cls == C_HALT) begin
                state <= S_HALT;
            end else if (last_step) begin
                state <= stop ? S_HALT : S_T0;
            end else begin
                case (state)
                    S_T0:    state <= S_T1;
                    S_T1:    state <= S_T2;
                    S_T2:    state <= S_T3;
                    S_T3:    state <= S_T4;
                    S_T4:    state <= S_T5;
                    S_T5:    state <= S_T6;
                    S_T6:    state <= S_T7;
                    S_HALT:  state <= S_HALT;
                    default: state <= S_T0;
                endcase
            end
        end
    end

    control_word_decode #(
        .ADD_OP (ADD_OP)
    ) u_decode (
        .state  (state),
        .opcode (opcode),
        .con_ff (con_ff),
        .cw     (cw_raw),
        .alu_op (alu_raw)
    );

    // Reset forces every strobe low immediately, even though the state already reads T0
    assign cw     = reset ? '0 : cw_raw;
    assign alu_op = reset ? 5'd0 : alu_raw;
    assign run    = reset || (state != S_HALT);

    assign Gra     = cw[CW_GRA];
    assign Grb     = cw[CW_GRB];
    assign Grc     = cw[CW_GRC];
    assign Rin     = cw[CW_RIN];
    assign Rout    = cw[CW_ROUT];
    assign BAout   = cw[CW_BAOUT];
    assign PCout   = cw[CW_PCOUT];
    assign PCin    = cw[CW_PCIN];
    assign IncPC   = cw[CW_INCPC];
    assign MARin   = cw[CW_MARIN];
    assign MDRin   = cw[CW_MDRIN];
    assign MDRout  = cw[CW_MDROUT];
    assign IRin    = cw[CW_IRIN];
    assign Yin     = cw[CW_YIN];
    assign Zin     = cw[CW_ZIN];
    assign Zlowout = cw[CW_ZLOWOUT];
    assign Cout    = cw[CW_COUT];
    assign CONin   = cw[CW_CONIN];
    assign Read    = cw[CW_READ];
    assign Write   = cw[CW_WRITE];

endmodule
